// File: rtl/constrained_register_bank.sv
// Bank of bounded up/down counters sharing one inc/dec button pair.
// Each channel is clamped to [MIN, MAX] and wraps or saturates at the bounds.
// A press steps the selected channel at once, then auto-repeats while held.
// A direct load path overrides stepping and parks the FSM until release.
module constrained_register_bank #(
    parameter int unsigned CHANNELS      = 4,
    parameter int unsigned WIDTH         = 10,
    parameter int unsigned MIN           = 0,
    parameter int unsigned MAX           = 359,
    parameter int unsigned STEP          = 1,
    parameter int unsigned FAST_STEP     = 10,
    parameter int unsigned WRAP          = 1,
    parameter int unsigned REPEAT_DELAY  = 25000000,
    parameter int unsigned REPEAT_PERIOD = 5000000
) (
    input  logic                         Clock,
    input  logic                         resetn,
    input  logic [$clog2(CHANNELS)-1:0]  sel,
    input  logic                         inc,
    input  logic                         dec,
    input  logic                         fast,
    input  logic                         load,
    input  logic [WIDTH-1:0]             load_val,
    output logic [CHANNELS*WIDTH-1:0]    out,
    output logic [CHANNELS-1:0]          changed
);

    localparam int unsigned SelW = $clog2(CHANNELS);
    localparam logic [SelW:0]  ChanN = (SelW+1)'(CHANNELS);
    localparam logic [WIDTH:0] MinV  = (WIDTH+1)'(MIN);
    localparam logic [WIDTH:0] MaxV  = (WIDTH+1)'(MAX);
    localparam logic [WIDTH:0] StepV = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0] FastV = (WIDTH+1)'(FAST_STEP);
    localparam bit             Wrap  = (WRAP != 0);

    typedef enum logic [1:0] {StIdle, StDelay, StRepeat, StLock} state_e;

    state_e              state_q, state_d;
    logic [SelW-1:0]     ch_q, ch_d;
    logic                dir_q, dir_d;       // 1 = up
    logic [31:0]         cnt_q, cnt_d;       // edges since the last step of this hold
    logic [WIDTH-1:0]    val_q [CHANNELS];
    logic [CHANNELS-1:0] changed_d;

    logic            press, sel_ok, load_ok;
    logic            do_step, step_dir;
    logic [SelW-1:0] step_ch, wr_ch;
    logic            wr_en;
    logic [WIDTH-1:0] cur, nv;
    logic [WIDTH:0]  cur_w, s_w, sum_w, lv_w, res_w;

    assign press   = inc ^ dec;
    assign sel_ok  = ({1'b0, sel} < ChanN);
    assign load_ok = load && sel_ok;

    // Hold FSM: decides whether a step happens this edge and on which channel.
    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        dir_d    = dir_q;
        cnt_d    = cnt_q;
        do_step  = 1'b0;
        step_dir = dir_q;
        step_ch  = ch_q;
        if (load_ok) begin
            state_d = press ? StLock : StIdle;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (press && sel_ok) begin
                        do_step  = 1'b1;
                        step_ch  = sel;
                        step_dir = inc;
                        ch_d     = sel;
                        dir_d    = inc;
                        cnt_d    = 32'd1;
                        state_d  = StDelay;
                    end
                end
                StDelay: begin
                    // A reversal counts as a release: no step on that edge.
                    if (!press || (inc != dir_q)) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else if (cnt_q >= REPEAT_DELAY) begin
                        do_step = 1'b1;
                        cnt_d   = 32'd1;
                        state_d = StRepeat;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                StRepeat: begin
                    if (!press || (inc != dir_q)) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else if (cnt_q >= REPEAT_PERIOD) begin
                        do_step = 1'b1;
                        cnt_d   = 32'd1;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                StLock: begin
                    if (!press) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Datapath: bounded step or clamped load on a single channel.
    always_comb begin
        wr_ch = load_ok ? sel : step_ch;
        wr_en = load_ok || do_step;
        cur   = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (wr_ch == SelW'(i)) cur = val_q[i];
        end
        cur_w = {1'b0, cur};
        s_w   = fast ? FastV : StepV;
        sum_w = cur_w + s_w;
        lv_w  = {1'b0, load_val};
        if (load_ok) begin
            if (lv_w < MinV)      res_w = MinV;
            else if (lv_w > MaxV) res_w = MaxV;
            else                  res_w = lv_w;
        end else if (step_dir) begin
            res_w = (sum_w > MaxV) ? (Wrap ? MinV : MaxV) : sum_w;
        end else begin
            // Compare against MIN + s so the subtraction never underflows.
            res_w = (cur_w < (MinV + s_w)) ? (Wrap ? MaxV : MinV) : (cur_w - s_w);
        end
        nv = res_w[WIDTH-1:0];
        changed_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            changed_d[i] = wr_en && (wr_ch == SelW'(i)) && (nv != val_q[i]);
        end
    end

    // State, channel values and change pulses; resetn is active-high.
    always_ff @(posedge Clock or posedge resetn) begin
        if (resetn) begin
            state_q <= StIdle;
            ch_q    <= '0;
            dir_q   <= 1'b0;
            cnt_q   <= '0;
            changed <= '0;
            for (int i = 0; i < CHANNELS; i++) val_q[i] <= MinV[WIDTH-1:0];
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            changed <= changed_d;
            for (int i = 0; i < CHANNELS; i++) begin
                if (changed_d[i]) val_q[i] <= nv;
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_out
        assign out[g*WIDTH +: WIDTH] = val_q[g];
    end

endmodule
